id_ex_stage: RTL and testbench

//  ID/EX pipeline register and EX-side operand front end of the 5-stage RISC pipeline.

---
 rtl/pipeline_pkg.sv | 35 +++
 rtl/alu_control.sv | 29 ++
 rtl/id_ex_stage.sv | 155 +++++++++++++++
 tb/tb_id_ex_stage.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared encodings for the ID/EX front end: ALU control codes, aluop/funct3 values,
// and the packed control/decode bundles carried through the pipeline register.
package pipeline_pkg;

    localparam logic [3:0] ALUCTRL_AND = 4'd0;
    localparam logic [3:0] ALUCTRL_OR  = 4'd1;
    localparam logic [3:0] ALUCTRL_ADD = 4'd2;
    localparam logic [3:0] ALUCTRL_SUB = 4'd6;
    localparam logic [3:0] ALUCTRL_NOP = 4'd15;

    localparam logic [1:0] ALUOP_MEM   = 2'b00;
    localparam logic [1:0] ALUOP_BR    = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_RSVD  = 2'b11;

    localparam logic [2:0] FUNCT3_ADDSUB = 3'b000;
    localparam logic [2:0] FUNCT3_OR     = 3'b110;
    localparam logic [2:0] FUNCT3_AND    = 3'b111;

    typedef struct packed {
        logic regwrite;
        logic memread;
        logic memwrite;
        logic memtoreg;
        logic branch;
    } ctrl_t;

    typedef struct packed {
        logic [1:0] aluop;
        logic [2:0] funct3;
        logic       funct7_30;
        logic       alusrc;
    } dec_t;

endpackage

// File: rtl/alu_control.sv
// ALU control decoder: aluop/funct3/funct7[30] -> 4-bit aluctrl.
// Combinational, zero latency; no flow control.
module alu_control
    import pipeline_pkg::*;
(
    input  logic [1:0] i_aluop,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7_30,
    output logic [3:0] o_aluctrl
);

    always_comb begin
        o_aluctrl = ALUCTRL_NOP;
        case (i_aluop)
            ALUOP_MEM: o_aluctrl = ALUCTRL_ADD;
            ALUOP_BR:  o_aluctrl = ALUCTRL_SUB;
            ALUOP_RTYPE: begin
                case (i_funct3)
                    FUNCT3_ADDSUB: o_aluctrl = i_funct7_30 ? ALUCTRL_SUB : ALUCTRL_ADD;
                    FUNCT3_AND:    o_aluctrl = ALUCTRL_AND;
                    FUNCT3_OR:     o_aluctrl = ALUCTRL_OR;
                    default:       o_aluctrl = ALUCTRL_NOP;
                endcase
            end
            default: o_aluctrl = ALUCTRL_NOP;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register plus EX operand front end (aluctrl, forwarded in1/in2, store data).
// One cycle ID->EX; stall holds, flush bubbles; ID_EX_FWD_EN enables EX/MEM and MEM/WB forwarding.
module id_ex_stage
    import pipeline_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int REGW  = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    stall,
    input  logic                    flush,
    input  logic                    id_valid,
    input  logic [WIDTH-1:0]        id_rs1_data,
    input  logic [WIDTH-1:0]        id_rs2_data,
    input  logic [WIDTH-1:0]        id_imm,
    input  logic [REGW-1:0]         id_rs1,
    input  logic [REGW-1:0]         id_rs2,
    input  logic [REGW-1:0]         id_rd,
    input  logic [1:0]              id_aluop,
    input  logic [2:0]              id_funct3,
    input  logic                    id_funct7_30,
    input  logic                    id_alusrc,
    input  logic                    id_regwrite,
    input  logic                    id_memread,
    input  logic                    id_memwrite,
    input  logic                    id_memtoreg,
    input  logic                    id_branch,
    input  logic                    exmem_regwrite,
    input  logic [REGW-1:0]         exmem_rd,
    input  logic [WIDTH-1:0]        exmem_result,
    input  logic                    memwb_regwrite,
    input  logic [REGW-1:0]         memwb_rd,
    input  logic [WIDTH-1:0]        memwb_result,
    output logic                    ex_valid,
    output logic [3:0]              aluctrl,
    output logic signed [WIDTH-1:0] in1,
    output logic signed [WIDTH-1:0] in2,
    output logic [WIDTH-1:0]        ex_store_data,
    output logic [REGW-1:0]         ex_rd,
    output logic                    ex_regwrite,
    output logic                    ex_memread,
    output logic                    ex_memwrite,
    output logic                    ex_memtoreg,
    output logic                    ex_branch
);

    ctrl_t            w_id_ctrl;
    dec_t             w_id_dec;
    logic             w_load;

    logic             r_valid;
    ctrl_t            r_ctrl;
    dec_t             r_dec;
    logic [WIDTH-1:0] r_rs1_data;
    logic [WIDTH-1:0] r_rs2_data;
    logic [WIDTH-1:0] r_imm;
    logic [REGW-1:0]  r_rs1;
    logic [REGW-1:0]  r_rs2;
    logic [REGW-1:0]  r_rd;

    logic [WIDTH-1:0] w_fwd_a;
    logic [WIDTH-1:0] w_fwd_b;

    assign w_id_ctrl = '{regwrite: id_regwrite, memread:  id_memread,
                         memwrite: id_memwrite, memtoreg: id_memtoreg,
                         branch:   id_branch};
    assign w_id_dec  = '{aluop: id_aluop, funct3: id_funct3,
                         funct7_30: id_funct7_30, alusrc: id_alusrc};

    // Flush still loads the data fields so a squashed slot carries the ID values.
    assign w_load = flush | ~stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (!stall) begin
            r_valid <= id_valid;
            r_ctrl  <= id_valid ? w_id_ctrl : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dec      <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
        end else if (w_load) begin
            r_dec      <= w_id_dec;
            r_rs1_data <= id_rs1_data;
            r_rs2_data <= id_rs2_data;
            r_imm      <= id_imm;
            r_rs1      <= id_rs1;
            r_rs2      <= id_rs2;
            r_rd       <= id_rd;
        end
    end

`ifdef ID_EX_FWD_EN
    // EX/MEM is the younger producer, so it is checked first; x0 never forwards.
    always_comb begin
        w_fwd_a = r_rs1_data;
        if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == r_rs1)) begin
            w_fwd_a = exmem_result;
        end else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == r_rs1)) begin
            w_fwd_a = memwb_result;
        end
    end

    always_comb begin
        w_fwd_b = r_rs2_data;
        if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == r_rs2)) begin
            w_fwd_b = exmem_result;
        end else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == r_rs2)) begin
            w_fwd_b = memwb_result;
        end
    end
`else
    logic w_fwd_unused;

    // Hazards are covered by stalling upstream; the bypass inputs stay on the port list.
    assign w_fwd_a      = r_rs1_data;
    assign w_fwd_b      = r_rs2_data;
    assign w_fwd_unused = ^{exmem_regwrite, exmem_rd, exmem_result,
                            memwb_regwrite, memwb_rd, memwb_result, r_rs1, r_rs2};
`endif

    alu_control u_alu_control (
        .i_aluop     (r_dec.aluop),
        .i_funct3    (r_dec.funct3),
        .i_funct7_30 (r_dec.funct7_30),
        .o_aluctrl   (aluctrl)
    );

    assign in1           = w_fwd_a;
    assign in2           = r_dec.alusrc ? r_imm : w_fwd_b;
    assign ex_store_data = w_fwd_b;

    assign ex_valid    = r_valid;
    assign ex_rd       = r_rd;
    assign ex_regwrite = r_ctrl.regwrite;
    assign ex_memread  = r_ctrl.memread;
    assign ex_memwrite = r_ctrl.memwrite;
    assign ex_memtoreg = r_ctrl.memtoreg;
    assign ex_branch   = r_ctrl.branch;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: decode table, hand-written stall/flush/forward/reset sequences,
// then randomized traffic against a behavioural model of the pipeline slot.
module tb_id_ex_stage;

    localparam int W = 64;
    localparam int R = 5;
`ifdef ID_EX_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic                clk;
    logic                rst_n;
    logic                stall;
    logic                flush;
    logic                id_valid;
    logic [W-1:0]        id_rs1_data;
    logic [W-1:0]        id_rs2_data;
    logic [W-1:0]        id_imm;
    logic [R-1:0]        id_rs1;
    logic [R-1:0]        id_rs2;
    logic [R-1:0]        id_rd;
    logic [1:0]          id_aluop;
    logic [2:0]          id_funct3;
    logic                id_funct7_30;
    logic                id_alusrc;
    logic                id_regwrite;
    logic                id_memread;
    logic                id_memwrite;
    logic                id_memtoreg;
    logic                id_branch;
    logic                exmem_regwrite;
    logic [R-1:0]        exmem_rd;
    logic [W-1:0]        exmem_result;
    logic                memwb_regwrite;
    logic [R-1:0]        memwb_rd;
    logic [W-1:0]        memwb_result;
    logic                ex_valid;
    logic [3:0]          aluctrl;
    logic signed [W-1:0] in1;
    logic signed [W-1:0] in2;
    logic [W-1:0]        ex_store_data;
    logic [R-1:0]        ex_rd;
    logic                ex_regwrite;
    logic                ex_memread;
    logic                ex_memwrite;
    logic                ex_memtoreg;
    logic                ex_branch;

    int checks;
    int errors;

    // Expected content of the EX slot; ctrl = {regwrite,memread,memwrite,memtoreg,branch}.
    typedef struct packed {
        logic        valid;
        logic [4:0]  ctrl;
        logic [1:0]  aluop;
        logic [2:0]  f3;
        logic        f7;
        logic        alusrc;
        logic [63:0] d1;
        logic [63:0] d2;
        logic [63:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } mdl_t;

    mdl_t mdl;

    typedef struct {
        logic [1:0]  aluop;
        logic [2:0]  f3;
        logic        f7;
        logic        alusrc;
        logic [63:0] d1;
        logic [63:0] d2;
        logic [63:0] imm;
        logic [3:0]  e_aluctrl;
        logic [63:0] e_in1;
        logic [63:0] e_in2;
    } vec_t;

    vec_t vecs[10];

    id_ex_stage #(.WIDTH(W), .REGW(R)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .flush          (flush),
        .id_valid       (id_valid),
        .id_rs1_data    (id_rs1_data),
        .id_rs2_data    (id_rs2_data),
        .id_imm         (id_imm),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_rd          (id_rd),
        .id_aluop       (id_aluop),
        .id_funct3      (id_funct3),
        .id_funct7_30   (id_funct7_30),
        .id_alusrc      (id_alusrc),
        .id_regwrite    (id_regwrite),
        .id_memread     (id_memread),
        .id_memwrite    (id_memwrite),
        .id_memtoreg    (id_memtoreg),
        .id_branch      (id_branch),
        .exmem_regwrite (exmem_regwrite),
        .exmem_rd       (exmem_rd),
        .exmem_result   (exmem_result),
        .memwb_regwrite (memwb_regwrite),
        .memwb_rd       (memwb_rd),
        .memwb_result   (memwb_result),
        .ex_valid       (ex_valid),
        .aluctrl        (aluctrl),
        .in1            (in1),
        .in2            (in2),
        .ex_store_data  (ex_store_data),
        .ex_rd          (ex_rd),
        .ex_regwrite    (ex_regwrite),
        .ex_memread     (ex_memread),
        .ex_memwrite    (ex_memwrite),
        .ex_memtoreg    (ex_memtoreg),
        .ex_branch      (ex_branch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] exp_aluctrl(input mdl_t m);
        if (m.aluop == 2'b00) return 4'd2;
        if (m.aluop == 2'b01) return 4'd6;
        if (m.aluop == 2'b11) return 4'd15;
        if (m.f3 == 3'b000)   return m.f7 ? 4'd6 : 4'd2;
        if (m.f3 == 3'b111)   return 4'd0;
        if (m.f3 == 3'b110)   return 4'd1;
        return 4'd15;
    endfunction

    function automatic logic [63:0] fwd_exp(input logic [4:0] rs, input logic [63:0] d);
        if (FWD && rs != 5'd0 && exmem_regwrite && exmem_rd == rs) return exmem_result;
        if (FWD && rs != 5'd0 && memwb_regwrite && memwb_rd == rs) return memwb_result;
        return d;
    endfunction

    task automatic check_all(input string tag);
        logic [63:0] eb;
        eb = fwd_exp(mdl.rs2, mdl.d2);
        chk({tag, ".valid"}, 64'(ex_valid), 64'(mdl.valid));
        chk({tag, ".ctrl"}, 64'({ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch}),
            64'(mdl.ctrl));
        chk({tag, ".rd"}, 64'(ex_rd), 64'(mdl.rd));
        chk({tag, ".aluctrl"}, 64'(aluctrl), 64'(exp_aluctrl(mdl)));
        chk({tag, ".in1"}, 64'(in1), fwd_exp(mdl.rs1, mdl.d1));
        chk({tag, ".in2"}, 64'(in2), mdl.alusrc ? mdl.imm : eb);
        chk({tag, ".store"}, ex_store_data, eb);
    endtask

    // One clock edge; the model follows flush > stall > capture.
    task automatic step();
        mdl_t n;
        n = mdl;
        if (flush || !stall) begin
            n.valid  = id_valid && !flush;
            n.ctrl   = n.valid ? {id_regwrite, id_memread, id_memwrite, id_memtoreg, id_branch}
                               : 5'd0;
            n.aluop  = id_aluop;
            n.f3     = id_funct3;
            n.f7     = id_funct7_30;
            n.alusrc = id_alusrc;
            n.d1     = id_rs1_data;
            n.d2     = id_rs2_data;
            n.imm    = id_imm;
            n.rs1    = id_rs1;
            n.rs2    = id_rs2;
            n.rd     = id_rd;
        end
        @(posedge clk);
        mdl = n;
        #1;
    endtask

    task automatic set_id(input logic v, input logic [1:0] op, input logic [2:0] f3,
                          input logic f7, input logic src, input logic [63:0] d1,
                          input logic [63:0] d2, input logic [63:0] imm, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd, input logic [4:0] ctrl);
        id_valid     = v;
        id_aluop     = op;
        id_funct3    = f3;
        id_funct7_30 = f7;
        id_alusrc    = src;
        id_rs1_data  = d1;
        id_rs2_data  = d2;
        id_imm       = imm;
        id_rs1       = rs1;
        id_rs2       = rs2;
        id_rd        = rd;
        {id_regwrite, id_memread, id_memwrite, id_memtoreg, id_branch} = ctrl;
    endtask

    task automatic clear_fwd();
        exmem_regwrite = 1'b0;
        exmem_rd       = '0;
        exmem_result   = '0;
        memwb_regwrite = 1'b0;
        memwb_rd       = '0;
        memwb_result   = '0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        vecs[0] = '{2'b10, 3'b000, 1'b1, 1'b0, 64'd5, 64'd3, 64'd0, 4'd6, 64'd5, 64'd3};
        vecs[1] = '{2'b10, 3'b000, 1'b0, 1'b0, 64'd9, 64'd4, 64'd0, 4'd2, 64'd9, 64'd4};
        vecs[2] = '{2'b10, 3'b111, 1'b0, 1'b0, 64'hF0, 64'h0F, 64'd0, 4'd0, 64'hF0, 64'h0F};
        vecs[3] = '{2'b10, 3'b110, 1'b0, 1'b0, 64'h1, 64'h2, 64'd0, 4'd1, 64'h1, 64'h2};
        vecs[4] = '{2'b10, 3'b001, 1'b0, 1'b0, 64'h3, 64'h4, 64'd0, 4'd15, 64'h3, 64'h4};
        vecs[5] = '{2'b10, 3'b111, 1'b1, 1'b0, 64'h5, 64'h6, 64'd0, 4'd0, 64'h5, 64'h6};
        vecs[6] = '{2'b00, 3'b011, 1'b0, 1'b1, 64'h100, 64'h7, 64'hFFFF_FFFF_FFFF_FFF8,
                    4'd2, 64'h100, 64'hFFFF_FFFF_FFFF_FFF8};
        vecs[7] = '{2'b01, 3'b000, 1'b0, 1'b0, 64'h8, 64'h8, 64'd0, 4'd6, 64'h8, 64'h8};
        vecs[8] = '{2'b11, 3'b000, 1'b0, 1'b0, 64'hA, 64'hB, 64'd0, 4'd15, 64'hA, 64'hB};
        vecs[9] = '{2'b10, 3'b100, 1'b1, 1'b0, 64'hC, 64'hD, 64'd0, 4'd15, 64'hC, 64'hD};

        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        clear_fwd();
        set_id(1'b0, 2'b10, 3'b111, 1'b1, 1'b1, 64'h1234, 64'h5678, 64'h9ABC, 5'd1, 5'd2, 5'd3,
               5'b11111);
        mdl = '0;
        #12;
        chk("rst_valid", 64'(ex_valid), 64'd0);
        chk("rst_regwrite", 64'(ex_regwrite), 64'd0);
        chk("rst_aluctrl", 64'(aluctrl), 64'd2);
        chk("rst_in1", 64'(in1), 64'd0);
        check_all("rst");
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            set_id(1'b1, vecs[i].aluop, vecs[i].f3, vecs[i].f7, vecs[i].alusrc, vecs[i].d1,
                   vecs[i].d2, vecs[i].imm, 5'd1, 5'd2, 5'd3, 5'b10000);
            step();
            chk($sformatf("vec%0d_aluctrl", i), 64'(aluctrl), 64'(vecs[i].e_aluctrl));
            chk($sformatf("vec%0d_in1", i), 64'(in1), vecs[i].e_in1);
            chk($sformatf("vec%0d_in2", i), 64'(in2), vecs[i].e_in2);
            check_all("vec");
        end

        // Stall holds for three cycles, then stall+flush bubbles with the new data.
        set_id(1'b1, 2'b10, 3'b000, 1'b0, 1'b0, 64'hA1, 64'hA2, 64'd0, 5'd1, 5'd2, 5'd9,
               5'b10000);
        step();
        check_all("ldA");
        set_id(1'b1, 2'b10, 3'b110, 1'b0, 1'b0, 64'hB1, 64'hB2, 64'd0, 5'd1, 5'd2, 5'd10,
               5'b01000);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_in1", 64'(in1), 64'hA1);
            chk("stall_rd", 64'(ex_rd), 64'd9);
            chk("stall_regwrite", 64'(ex_regwrite), 64'd1);
            check_all("stall");
        end
        flush = 1'b1;
        step();
        chk("flush_valid", 64'(ex_valid), 64'd0);
        chk("flush_memread", 64'(ex_memread), 64'd0);
        chk("flush_in1", 64'(in1), 64'hB1);
        check_all("flush");
        stall = 1'b0;
        flush = 1'b0;

        // Forward priority on rs1.
        set_id(1'b1, 2'b10, 3'b000, 1'b0, 1'b0, 64'h99, 64'h98, 64'd0, 5'd7, 5'd6, 5'd1,
               5'b10000);
        step();
        exmem_regwrite = 1'b1; exmem_rd = 5'd7; exmem_result = 64'h11;
        memwb_regwrite = 1'b1; memwb_rd = 5'd7; memwb_result = 64'h22;
        #1;
        chk("fwd_prio_in1", 64'(in1), FWD ? 64'h11 : 64'h99);
        check_all("fwd_prio");
        exmem_regwrite = 1'b0;
        #1;
        chk("fwd_memwb_in1", 64'(in1), FWD ? 64'h22 : 64'h99);
        check_all("fwd_memwb");
        clear_fwd();

        // x0 is never a forwarding target.
        set_id(1'b1, 2'b10, 3'b000, 1'b0, 1'b0, 64'h44, 64'h55, 64'd0, 5'd3, 5'd0, 5'd2,
               5'b10000);
        step();
        exmem_regwrite = 1'b1; exmem_rd = 5'd0; exmem_result = 64'h77;
        memwb_regwrite = 1'b1; memwb_rd = 5'd0; memwb_result = 64'h66;
        #1;
        chk("x0_in2", 64'(in2), 64'h55);
        chk("x0_store", ex_store_data, 64'h55);
        check_all("x0");
        clear_fwd();

        // Store: immediate on in2, forwarded rs2 on store data.
        set_id(1'b1, 2'b00, 3'b011, 1'b0, 1'b1, 64'h40, 64'h10, 64'hFFFF_FFFF_FFFF_FFF8, 5'd3,
               5'd4, 5'd5, 5'b00100);
        step();
        exmem_regwrite = 1'b1; exmem_rd = 5'd4; exmem_result = 64'hAB;
        #1;
        chk("st_in2", 64'(in2), 64'hFFFF_FFFF_FFFF_FFF8);
        chk("st_aluctrl", 64'(aluctrl), 64'd2);
        chk("st_store", ex_store_data, FWD ? 64'hAB : 64'h10);
        check_all("st");
        clear_fwd();

        // id_valid=0 gates every control bit.
        set_id(1'b0, 2'b10, 3'b000, 1'b0, 1'b0, 64'h1, 64'h2, 64'd0, 5'd1, 5'd2, 5'd3,
               5'b11111);
        step();
        chk("bubble_valid", 64'(ex_valid), 64'd0);
        chk("bubble_ctrl", 64'({ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch}),
            64'd0);
        check_all("bubble");

        // Asynchronous reset between clock edges.
        set_id(1'b1, 2'b10, 3'b111, 1'b0, 1'b0, 64'h31, 64'h32, 64'd0, 5'd1, 5'd2, 5'd4,
               5'b10011);
        step();
        chk("pre_arst_valid", 64'(ex_valid), 64'd1);
        #3;
        rst_n = 1'b0;
        #1;
        mdl = '0;
        chk("arst_valid", 64'(ex_valid), 64'd0);
        chk("arst_regwrite", 64'(ex_regwrite), 64'd0);
        check_all("arst");
        #2;
        rst_n = 1'b1;

        for (int i = 0; i < 400; i++) begin
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 9) == 0);
            set_id(1'($urandom), 2'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
                   {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom),
                   5'($urandom));
            exmem_regwrite = 1'($urandom);
            exmem_rd       = 5'($urandom_range(0, 7));
            exmem_result   = {$urandom, $urandom};
            memwb_regwrite = 1'($urandom);
            memwb_rd       = 5'($urandom_range(0, 7));
            memwb_result   = {$urandom, $urandom};
            step();
            check_all("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
